// File: rtl/uart_byte_receiver_pkg.sv
// Shared definitions for the UART byte receiver and its downstream command receiver.
//   DATA_BITS     data bits per frame
//   BIT_IDX_W     width of the data-bit index
//   CMD_BYTE_W    byte width consumed by the command receiver
//   rx_state_t    receiver FSM state encodings
//   rx_out_t      registered strobe/data payload presented on the output ports
package uart_byte_receiver_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned BIT_IDX_W  = $clog2(DATA_BITS);
    localparam int unsigned CMD_BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    typedef struct packed {
        logic                 valid;
        logic                 framing_error;
        logic                 parity_error;
        logic [DATA_BITS-1:0] data;
    } rx_out_t;

    // Parity bit the transmitter should have sent for this byte.
    function automatic logic expected_parity(input logic [DATA_BITS-1:0] data,
                                             input logic                 odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_byte_receiver_sync_2ff.sv
// Two-flop synchronizer for asynchronous pin inputs, parameterised width and reset value.
//   clock  system clock
//   reset  synchronous, active-high; both stages load RESET_VAL
//   d      asynchronous input
//   q      synchronized output (two clocks of latency)
module uart_byte_receiver_sync_2ff #(
    parameter int unsigned          WIDTH     = 1,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_byte_receiver.sv
// 8-bit asynchronous serial receiver (LSB first, 1 stop bit), mid-bit sampling.
// Optional parity bit when the UART_RX_PARITY_EN macro is defined (PARITY_ODD selects odd parity).
//   clock               system clock, rising edge
//   reset               synchronous, active-high
//   rx                  asynchronous serial line, idles high
//   serial_output_data  last good byte, held until the next one
//   serial_output_valid one-cycle strobe, new byte on serial_output_data
//   framing_error       one-cycle strobe, stop bit sampled low
//   parity_error        one-cycle strobe, parity mismatch (constant 0 without parity)
//   busy                high whenever the FSM is not idle
module uart_byte_receiver
    import uart_byte_receiver_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 417,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] serial_output_data,
    output logic                 serial_output_valid,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic                 busy
);

    localparam int unsigned    CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int unsigned    HALF_BIT  = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    // Elaboration-time parameter checks.
    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
        $error("uart_byte_receiver: CLKS_PER_BIT must be >= 4");
    end
    if (PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_byte_receiver: PARITY_ODD must be 0 or 1");
    end
    if (DATA_BITS != CMD_BYTE_W) begin : g_bad_byte_width
        $error("uart_byte_receiver: byte width must match the command receiver");
    end

    logic                  rx_s;
    logic [1:0]            settle;
    rx_state_t             state;
    rx_state_t             state_nx;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nx;
    logic [BIT_IDX_W-1:0]  bit_idx;
    logic [BIT_IDX_W-1:0]  bit_idx_nx;
    logic [DATA_BITS-1:0]  shift;
    logic [DATA_BITS-1:0]  shift_nx;
    logic                  armed;
    logic                  armed_nx;
    logic                  busy_q;
    logic                  busy_nx;
    rx_out_t               out_q;
    rx_out_t               out_nx;
    logic                  sample_pt;
`ifdef UART_RX_PARITY_EN
    logic                  par_bad;
    logic                  par_bad_nx;
`endif

    // Pin synchronizer; line idles high so the flops reset to 1.
    uart_byte_receiver_sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // The synchronizer still shows its reset value of 1 for one cycle after reset;
    // arming is held off until real pin data has reached rx_s so a line held low
    // through reset cannot look like a high-then-low start edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            settle <= 2'b00;
        end else begin
            settle <= {settle[0], 1'b1};
        end
    end

    // Start sample is half a bit in; every later sample is one full bit apart.
    assign sample_pt = (state == ST_START) ? (cnt == HALF_LAST) : (cnt == FULL_LAST);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (armed && !rx_s) state_nx = ST_START;
            end
            ST_START: begin
                if (sample_pt) state_nx = rx_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (sample_pt && (bit_idx == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    state_nx = ST_PARITY;
`else
                    state_nx = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (sample_pt) state_nx = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (sample_pt) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        cnt_nx               = cnt;
        bit_idx_nx           = bit_idx;
        shift_nx             = shift;
        armed_nx             = armed;
        busy_nx              = (state_nx != ST_IDLE);
        out_nx               = '0;
        out_nx.data          = out_q.data;
`ifdef UART_RX_PARITY_EN
        par_bad_nx           = par_bad;
`endif

        // Per-bit counter restarts at every sample point.
        if (state == ST_IDLE) begin
            cnt_nx = '0;
        end else if (sample_pt) begin
            cnt_nx = '0;
        end else begin
            cnt_nx = cnt + CNT_W'(1);
        end

        case (state)
            ST_IDLE: begin
                bit_idx_nx = '0;
                if (settle[1] && rx_s) armed_nx = 1'b1;
            end
            ST_START: begin
                if (sample_pt) begin
                    bit_idx_nx = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_nx = 1'b0;
`endif
                end
            end
            ST_DATA: begin
                if (sample_pt) begin
                    shift_nx   = {rx_s, shift[DATA_BITS-1:1]};
                    bit_idx_nx = bit_idx + BIT_IDX_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (sample_pt) par_bad_nx = (rx_s != expected_parity(shift, 1'(PARITY_ODD)));
            end
`endif
            ST_STOP: begin
                if (sample_pt) begin
                    if (!rx_s) begin
                        // Broken frame: disarm until the line is seen idle again.
                        out_nx.framing_error = 1'b1;
                        armed_nx             = 1'b0;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad) begin
                        out_nx.parity_error  = 1'b1;
`endif
                    end else begin
                        out_nx.valid = 1'b1;
                        out_nx.data  = shift;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            armed   <= 1'b0;
            busy_q  <= 1'b0;
            out_q   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            cnt     <= cnt_nx;
            bit_idx <= bit_idx_nx;
            shift   <= shift_nx;
            armed   <= armed_nx;
            busy_q  <= busy_nx;
            out_q   <= out_nx;
`ifdef UART_RX_PARITY_EN
            par_bad <= par_bad_nx;
`endif
        end
    end

    assign serial_output_data  = out_q.data;
    assign serial_output_valid = out_q.valid;
    assign framing_error       = out_q.framing_error;
    assign parity_error        = out_q.parity_error;
    assign busy                = busy_q;

endmodule
